// File: rtl/decode_stage.sv
// RV32 ID stage: drives reg_file read addresses, decodes fields/immediate, captures operands into one ID/EX register.
// Latency: one cycle from an accepted if_instr to ex_valid; reg_file reads and the decode are combinational.
// Backpressure: if_ready drops on flush, a load-use hazard, a WB read-after-write (no-bypass build) or a full, stalled ID/EX.
// Build option: define DECODE_WB_BYPASS_EN to forward wb_dataW into the operands instead of stalling for one cycle.
module decode_stage #(
   parameter int         XLEN        = 32,
   parameter logic [6:0] LOAD_OPCODE = 7'b0000011
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            flush,
   input  logic            if_valid,
   output logic            if_ready,
   input  logic [31:0]     if_instr,
   input  logic [XLEN-1:0] if_pc,
   output logic [4:0]      rs1,
   output logic [4:0]      rs2,
   input  logic [XLEN-1:0] data1,
   input  logic [XLEN-1:0] data2,
   input  logic            wb_RegWEn,
   input  logic [4:0]      wb_rsW,
   input  logic [XLEN-1:0] wb_dataW,
   output logic            ex_valid,
   input  logic            ex_ready,
   output logic [XLEN-1:0] ex_pc,
   output logic [XLEN-1:0] ex_rs1_val,
   output logic [XLEN-1:0] ex_rs2_val,
   output logic [4:0]      ex_rd,
   output logic [XLEN-1:0] ex_imm,
   output logic [6:0]      ex_opcode,
   output logic [2:0]      ex_funct3,
   output logic            ex_funct7b5,
   output logic            ex_reg_wen
);

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_SYSTEM = 7'b1110011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_REG    = 7'b0110011;

   // ID/EX pipeline register
   logic            r_ex_valid;
   logic [XLEN-1:0] r_ex_pc;
   logic [XLEN-1:0] r_ex_rs1_val;
   logic [XLEN-1:0] r_ex_rs2_val;
   logic [4:0]      r_ex_rd;
   logic [XLEN-1:0] r_ex_imm;
   logic [6:0]      r_ex_opcode;
   logic [2:0]      r_ex_funct3;
   logic            r_ex_funct7b5;
   logic            r_ex_reg_wen;

   // decode of the instruction currently presented by fetch
   logic [6:0]      w_opcode;
   logic [4:0]      w_rd;
   logic [XLEN-1:0] w_imm;
   logic            w_use_rs1;
   logic            w_use_rs2;
   logic            w_reg_wen;
   logic            w_load_use;
   logic            w_wb_hit1;
   logic            w_wb_hit2;
   logic            w_wb_stall;
   logic [XLEN-1:0] w_op1;
   logic [XLEN-1:0] w_op2;
   logic            w_accept;

   assign w_opcode = if_instr[6:0];
   assign w_rd     = if_instr[11:7];
   assign rs1      = if_instr[19:15];
   assign rs2      = if_instr[24:20];

   // Immediate extraction by instruction format; unknown opcodes carry no immediate
   always_comb begin
      w_imm = '0;
      case (w_opcode)
         OP_LOAD, OP_IMM, OP_JALR, OP_SYSTEM:
            w_imm = {{(XLEN-12){if_instr[31]}}, if_instr[31:20]};
         OP_STORE:
            w_imm = {{(XLEN-12){if_instr[31]}}, if_instr[31:25], if_instr[11:7]};
         OP_BRANCH:
            w_imm = {{(XLEN-12){if_instr[31]}}, if_instr[7], if_instr[30:25], if_instr[11:8], 1'b0};
         OP_LUI, OP_AUIPC:
            w_imm = {{(XLEN-32){if_instr[31]}}, if_instr[31:12], 12'b0};
         OP_JAL:
            w_imm = {{(XLEN-20){if_instr[31]}}, if_instr[19:12], if_instr[20], if_instr[30:21], 1'b0};
         default:
            w_imm = '0;
      endcase
   end

   assign w_use_rs1 = !((w_opcode == OP_LUI) || (w_opcode == OP_AUIPC) || (w_opcode == OP_JAL));
   assign w_use_rs2 = (w_opcode == OP_REG) || (w_opcode == OP_STORE) || (w_opcode == OP_BRANCH);
   assign w_reg_wen = !((w_opcode == OP_STORE) || (w_opcode == OP_BRANCH) || (w_rd == 5'd0));

   // A load in EX cannot deliver its data in time for a dependent instruction in ID
   assign w_load_use = r_ex_valid && (r_ex_opcode == LOAD_OPCODE) && (r_ex_rd != 5'd0) &&
                       ((w_use_rs1 && (rs1 == r_ex_rd)) || (w_use_rs2 && (rs2 == r_ex_rd)));

   // Writeback targeting a source register this cycle; x0 never matches
   assign w_wb_hit1 = wb_RegWEn && (wb_rsW != 5'd0) && (wb_rsW == rs1);
   assign w_wb_hit2 = wb_RegWEn && (wb_rsW != 5'd0) && (wb_rsW == rs2);

`ifdef DECODE_WB_BYPASS_EN
   assign w_wb_stall = 1'b0;
`else
   // The reg_file write lands at this edge, so hold off one cycle and read the updated value.
   // The hit is not qualified by source use so both captured operands are always current.
   assign w_wb_stall = w_wb_hit1 || w_wb_hit2;
`endif

   // The forwarding mux is shared by both builds: without bypass a hit always stalls, so
   // the wb_dataW leg is never captured there.
   assign w_op1 = (rs1 == 5'd0) ? '0 : (w_wb_hit1 ? wb_dataW : data1);
   assign w_op2 = (rs2 == 5'd0) ? '0 : (w_wb_hit2 ? wb_dataW : data2);

   assign if_ready = !rst && !flush && !w_load_use && !w_wb_stall && (!r_ex_valid || ex_ready);
   assign w_accept = if_valid && if_ready;

   // ID/EX register: reset clears, flush kills, capture on handshake, drain when execute consumes
   always_ff @(posedge clk) begin
      if (rst) begin
         r_ex_valid    <= 1'b0;
         r_ex_pc       <= '0;
         r_ex_rs1_val  <= '0;
         r_ex_rs2_val  <= '0;
         r_ex_rd       <= '0;
         r_ex_imm      <= '0;
         r_ex_opcode   <= '0;
         r_ex_funct3   <= '0;
         r_ex_funct7b5 <= 1'b0;
         r_ex_reg_wen  <= 1'b0;
      end else if (flush) begin
         r_ex_valid <= 1'b0;
      end else if (w_accept) begin
         r_ex_valid    <= 1'b1;
         r_ex_pc       <= if_pc;
         r_ex_rs1_val  <= w_op1;
         r_ex_rs2_val  <= w_op2;
         r_ex_rd       <= w_rd;
         r_ex_imm      <= w_imm;
         r_ex_opcode   <= w_opcode;
         r_ex_funct3   <= if_instr[14:12];
         r_ex_funct7b5 <= if_instr[30];
         r_ex_reg_wen  <= w_reg_wen;
      end else if (ex_ready && r_ex_valid) begin
         r_ex_valid <= 1'b0;
      end
   end

   assign ex_valid    = r_ex_valid;
   assign ex_pc       = r_ex_pc;
   assign ex_rs1_val  = r_ex_rs1_val;
   assign ex_rs2_val  = r_ex_rs2_val;
   assign ex_rd       = r_ex_rd;
   assign ex_imm      = r_ex_imm;
   assign ex_opcode   = r_ex_opcode;
   assign ex_funct3   = r_ex_funct3;
   assign ex_funct7b5 = r_ex_funct7b5;
   assign ex_reg_wen  = r_ex_reg_wen;

endmodule
